// File: rtl/asic_iopoc_pkg.sv
// Shared types and helpers for the IO ring power-on-control sequencer.
package asic_iopoc_pkg;

  // State encodings, kept as named constants so the enum and any debug
  // decoding agree on the same values.
  localparam logic [2:0] ST_IDLE_ENC    = 3'd0;
  localparam logic [2:0] ST_WAIT_OK_ENC = 3'd1;
  localparam logic [2:0] ST_SETTLE_ENC  = 3'd2;
  localparam logic [2:0] ST_RELEASE_ENC = 3'd3;
  localparam logic [2:0] ST_DONE_ENC    = 3'd4;
  localparam logic [2:0] ST_FAULT_ENC   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE    = ST_IDLE_ENC,
    ST_WAIT_OK = ST_WAIT_OK_ENC,
    ST_SETTLE  = ST_SETTLE_ENC,
    ST_RELEASE = ST_RELEASE_ENC,
    ST_DONE    = ST_DONE_ENC,
    ST_FAULT   = ST_FAULT_ENC
  } state_t;

  // Ceiling log2 usable in constant expressions; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/asic_dsync.sv
// Two-flop synchronizer bank for slow level signals entering the clk domain.
module asic_dsync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  // Two back-to-back capture stages; the first may go metastable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/asic_iopoc_seq.sv
// Power-on-control sequencer: releases pad-ring segments one at a time once
// each segment's IO supply is good and settled; re-clamps everything on a
// supply timeout, a brown-out, or a power-down request.
module asic_iopoc_seq
  import asic_iopoc_pkg::*;
#(
  parameter int NSEG    = 4,
  parameter int CNTW    = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [CNTW-1:0] settle,
  input  logic [NSEG-1:0] vddio_ok,
  output logic [NSEG-1:0] poc,
  output logic [NSEG-1:0] seg_ready,
  output logic            ready,
  output logic            fault,
  output logic            busy
);

  localparam int IW = (NSEG > 1) ? clog2(NSEG) : 1;
  localparam int WW = clog2(TIMEOUT);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NSEG - 1);

  state_t          state_reg,     state_next;
  logic [IW-1:0]   idx_reg,       idx_next;
  logic [WW-1:0]   wait_cnt_reg,  wait_cnt_next;
  logic [CNTW-1:0] set_cnt_reg,   set_cnt_next;
  logic [CNTW-1:0] set_lim_reg,   set_lim_next;
  logic [NSEG-1:0] poc_reg,       poc_next;
  logic [NSEG-1:0] seg_ready_reg, seg_ready_next;
  logic [NSEG-1:0] ok_sync;

  asic_dsync #(
    .WIDTH(NSEG)
  ) u_ok_sync (
    .clk  (clk),
    .reset(reset),
    .d    (vddio_ok),
    .q    (ok_sync)
  );

  // State and datapath registers; reset re-clamps every pad immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      wait_cnt_reg  <= '0;
      set_cnt_reg   <= '0;
      set_lim_reg   <= '0;
      poc_reg       <= '1;
      seg_ready_reg <= '0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      wait_cnt_reg  <= wait_cnt_next;
      set_cnt_reg   <= set_cnt_next;
      set_lim_reg   <= set_lim_next;
      poc_reg       <= poc_next;
      seg_ready_reg <= seg_ready_next;
    end
  end

  // Next-state and datapath updates. en low outranks every other event
  // (except in FAULT, where it is the only exit), and a supply-good seen in
  // the same cycle as the timeout outranks the timeout.
  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    wait_cnt_next  = wait_cnt_reg;
    set_cnt_next   = set_cnt_reg;
    set_lim_next   = set_lim_reg;
    poc_next       = poc_reg;
    seg_ready_next = seg_ready_reg;

    if (!en && state_reg != ST_FAULT) begin
      state_next     = ST_IDLE;
      poc_next       = '1;
      seg_ready_next = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          poc_next       = '1;
          seg_ready_next = '0;
          idx_next       = '0;
          wait_cnt_next  = '0;
          state_next     = ST_WAIT_OK;
        end

        ST_WAIT_OK: begin
          if (ok_sync[idx_reg]) begin
            wait_cnt_next = '0;
            set_cnt_next  = '0;
            // A zero settle request still needs one cycle of settling.
            set_lim_next  = (settle == '0) ? CNTW'(1) : settle;
            state_next    = ST_SETTLE;
          end else if (wait_cnt_reg == WAIT_LAST) begin
            poc_next       = '1;
            seg_ready_next = '0;
            state_next     = ST_FAULT;
          end else if (wait_cnt_reg != '1) begin
            wait_cnt_next = wait_cnt_reg + WW'(1);
          end
        end

        ST_SETTLE: begin
          if (!ok_sync[idx_reg]) begin
            // Supply glitched: wait for it again from scratch.
            wait_cnt_next = '0;
            set_cnt_next  = '0;
            state_next    = ST_WAIT_OK;
          end else if (set_cnt_reg == set_lim_reg - CNTW'(1)) begin
            set_cnt_next = '0;
            state_next   = ST_RELEASE;
          end else if (set_cnt_reg != '1) begin
            set_cnt_next = set_cnt_reg + CNTW'(1);
          end
        end

        ST_RELEASE: begin
          poc_next[idx_reg]       = 1'b0;
          seg_ready_next[idx_reg] = 1'b1;
          if (idx_reg == IDX_LAST) begin
            state_next = ST_DONE;
          end else begin
            idx_next      = idx_reg + IW'(1);
            wait_cnt_next = '0;
            state_next    = ST_WAIT_OK;
          end
        end

        ST_DONE: begin
          // Brown-out on any released segment.
          if ((~ok_sync & seg_ready_reg) != '0) begin
            poc_next       = '1;
            seg_ready_next = '0;
            state_next     = ST_FAULT;
          end
        end

        ST_FAULT: begin
          poc_next       = '1;
          seg_ready_next = '0;
          if (!en) state_next = ST_IDLE;
        end

        default: begin
          poc_next       = '1;
          seg_ready_next = '0;
          state_next     = ST_IDLE;
        end
      endcase
    end
  end

  assign poc       = poc_reg;
  assign seg_ready = seg_ready_reg;
  assign ready     = (state_reg == ST_DONE);
  assign fault     = (state_reg == ST_FAULT);
  assign busy      = (state_reg == ST_WAIT_OK) || (state_reg == ST_SETTLE) ||
                     (state_reg == ST_RELEASE);

endmodule

// File: tb/tb_asic_iopoc_seq.sv
// Directed bench for the POC sequencer; every poc change is matched against a
// queue of expected (value, cycle) pairs pushed when the stimulus is applied.
module tb_asic_iopoc_seq;

  localparam int NSEG    = 4;
  localparam int CNTW    = 8;
  localparam int TIMEOUT = 16;

  logic            clk;
  logic            reset;
  logic            en;
  logic [CNTW-1:0] settle;
  logic [NSEG-1:0] vddio_ok;
  logic [NSEG-1:0] poc;
  logic [NSEG-1:0] seg_ready;
  logic            ready;
  logic            fault;
  logic            busy;

  asic_iopoc_seq #(
    .NSEG   (NSEG),
    .CNTW   (CNTW),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .settle   (settle),
    .vddio_ok (vddio_ok),
    .poc      (poc),
    .seg_ready(seg_ready),
    .ready    (ready),
    .fault    (fault),
    .busy     (busy)
  );

  typedef struct {
    logic [NSEG-1:0] poc;
    int              cyc;
  } exp_t;

  exp_t            exp_q[$];
  exp_t            mon_e;
  int              checks   = 0;
  int              failures = 0;
  int              cyc      = 0;
  bit              mon_on   = 0;
  logic [NSEG-1:0] prev_poc;
  int              c0, c1, d;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic go_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic push(input logic [NSEG-1:0] p, input int c);
    exp_t e;
    e.poc = p;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  // Full power-up from IDLE with every supply already good, en raised at cycle c.
  task automatic push_run(input int c, input int s);
    int se;
    logic [NSEG-1:0] v;
    se = (s == 0) ? 1 : s;
    for (int i = 0; i < NSEG; i++) begin
      v = NSEG'(4'hF << (i + 1));
      push(v, c + 1 + (i + 1) * (se + 2));
    end
  endtask

  // Scoreboard: each observed poc change must match the next expectation.
  always @(negedge clk) begin
    if (mon_on) begin
      if (poc !== prev_poc) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $error("FAIL poc_unexpected observed=%0h expected=none cyc=%0d", poc, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("poc_value", 32'(poc), 32'(mon_e.poc));
          chk("poc_cycle", cyc, mon_e.cyc);
          $display("poc change cyc=%0d poc=%b", cyc, poc);
        end
      end
      prev_poc = poc;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    en       = 1'b0;
    settle   = 8'd3;
    vddio_ok = '0;
    step(2);
    chk("rst_poc", 32'(poc), 32'hF);
    chk("rst_seg_ready", 32'(seg_ready), 0);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_busy", 32'(busy), 0);
    reset    = 1'b0;
    prev_poc = poc;
    mon_on   = 1'b1;

    // Normal ordered power-up, settle = 3.
    vddio_ok = 4'hF;
    step(3);
    c0 = cyc;
    en = 1'b1;
    push_run(c0, 3);
    go_to(c0 + 2);
    chk("t1_busy", 32'(busy), 1);
    go_to(c0 + 20);
    chk("t1_ready_early", 32'(ready), 0);
    go_to(c0 + 21);
    chk("t1_ready", 32'(ready), 1);
    chk("t1_busy_done", 32'(busy), 0);
    chk("t1_fault", 32'(fault), 0);
    chk("t1_seg_ready", 32'(seg_ready), 32'hF);
    en = 1'b0;
    push(4'hF, cyc + 1);
    step(1);
    chk("t1_off_ready", 32'(ready), 0);
    chk("t1_off_seg_ready", 32'(seg_ready), 0);

    // Segment 2 supply never comes up: timeout.
    vddio_ok = 4'b1011;
    step(3);
    c0 = cyc;
    en = 1'b1;
    push(4'hE, c0 + 6);
    push(4'hC, c0 + 11);
    push(4'hF, c0 + 27);
    go_to(c0 + 26);
    chk("t2_fault_before", 32'(fault), 0);
    chk("t2_busy_wait", 32'(busy), 1);
    go_to(c0 + 27);
    chk("t2_fault", 32'(fault), 1);
    chk("t2_busy", 32'(busy), 0);
    chk("t2_seg_ready", 32'(seg_ready), 0);
    step(4);
    chk("t2_fault_sticky", 32'(fault), 1);
    en = 1'b0;
    step(1);
    chk("t2_fault_clear", 32'(fault), 0);

    // Brown-out on segment 1 after reaching DONE.
    vddio_ok = 4'hF;
    step(3);
    c0 = cyc;
    en = 1'b1;
    push_run(c0, 3);
    go_to(c0 + 22);
    chk("t3_ready", 32'(ready), 1);
    d = cyc;
    vddio_ok = 4'b1101;
    push(4'hF, d + 3);
    step(2);
    chk("t3_ready_hold", 32'(ready), 1);
    step(1);
    chk("t3_ready_drop", 32'(ready), 0);
    chk("t3_fault", 32'(fault), 1);
    chk("t3_seg_ready", 32'(seg_ready), 0);
    en = 1'b0;
    vddio_ok = 4'hF;
    step(1);
    chk("t3_fault_clear", 32'(fault), 0);

    // Power-down while settling segment 2, then restart from segment 0.
    step(3);
    c0 = cyc;
    en = 1'b1;
    push(4'hE, c0 + 6);
    push(4'hC, c0 + 11);
    push(4'hF, c0 + 14);
    go_to(c0 + 13);
    chk("t4_busy", 32'(busy), 1);
    en = 1'b0;
    step(1);
    chk("t4_busy_off", 32'(busy), 0);
    chk("t4_seg_ready", 32'(seg_ready), 0);
    c1 = cyc;
    en = 1'b1;
    push_run(c1, 3);
    go_to(c1 + 6);
    chk("t4_restart_seg0", 32'(seg_ready), 32'h1);
    go_to(c1 + 21);
    chk("t4_ready", 32'(ready), 1);
    en = 1'b0;
    push(4'hF, cyc + 1);
    step(1);

    // settle = 0 behaves as one settle cycle.
    settle = 8'd0;
    c0 = cyc;
    en = 1'b1;
    push_run(c0, 0);
    go_to(c0 + 13);
    chk("t5_ready", 32'(ready), 1);
    en = 1'b0;
    push(4'hF, cyc + 1);
    step(1);

    // One-cycle glitch on segment 0 supply during SETTLE delays its release.
    settle = 8'd3;
    c0 = cyc;
    en = 1'b1;
    step(1);
    vddio_ok = 4'b1110;
    step(1);
    vddio_ok = 4'hF;
    push(4'hE, c0 + 9);
    push(4'hC, c0 + 14);
    push(4'h8, c0 + 19);
    push(4'h0, c0 + 24);
    go_to(c0 + 24);
    chk("t5g_ready", 32'(ready), 1);
    en = 1'b0;
    push(4'hF, cyc + 1);
    step(1);

    // Asynchronous reset while waiting on segment 3.
    vddio_ok = 4'b0111;
    step(3);
    c0 = cyc;
    en = 1'b1;
    push(4'hE, c0 + 6);
    push(4'hC, c0 + 11);
    push(4'h8, c0 + 16);
    go_to(c0 + 18);
    chk("t6_busy", 32'(busy), 1);
    chk("t6_seg_ready_pre", 32'(seg_ready), 32'h7);
    #3;
    reset = 1'b1;
    en    = 1'b0;
    #1;
    chk("t6_poc", 32'(poc), 32'hF);
    chk("t6_seg_ready", 32'(seg_ready), 0);
    chk("t6_ready", 32'(ready), 0);
    chk("t6_busy_rst", 32'(busy), 0);
    chk("t6_fault", 32'(fault), 0);
    push(4'hF, cyc + 1);
    step(2);
    reset = 1'b0;
    step(2);
    chk("t6_idle_busy", 32'(busy), 0);
    chk("t6_idle_poc", 32'(poc), 32'hF);

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
